// File: rtl/ddr_fsm_pkg.sv
// Shared definitions for the DDR bank timing FSM: bank state codes,
// default timing values and the width of the shared timing down-counter.
package ddr_fsm_pkg;

  // Default timing values in clock cycles.
  localparam int unsigned DEF_TRCD = 4;
  localparam int unsigned DEF_TCL  = 5;
  localparam int unsigned DEF_TCWL = 4;
  localparam int unsigned DEF_TRP  = 4;
  localparam int unsigned DEF_TRFC = 16;
  localparam int unsigned DEF_BL   = 8;

  // Bank state codes. The bank data path decodes these values directly,
  // so the encodings are fixed rather than left to the synthesis tool.
  typedef enum logic [4:0] {
    S_IDLE        = 5'b00000,
    S_ACTIVATING  = 5'b00001,
    S_BANK_ACTIVE = 5'b00010,
    S_PRECHARGING = 5'b00100,
    S_REFRESHING  = 5'b00101,
    S_READ_WAIT   = 5'b01010,
    S_READING     = 5'b01011,
    S_READING_AP  = 5'b01100,
    S_WRITE_WAIT  = 5'b10001,
    S_WRITING     = 5'b10010,
    S_WRITING_AP  = 5'b10011
  } bank_state_e;

  // Counter width for a set of timing parameters: clog2 of the largest one.
  // The counter is loaded with (parameter - 1), which always fits in that
  // width. The width is at least 1 bit so that all-ones timings still work.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d,
                                            input int unsigned e, input int unsigned f);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    if (f > m) m = f;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  // Counter width for the default timing set.
  localparam int unsigned CNT_W = cnt_width(DEF_TRCD, DEF_TCL, DEF_TCWL,
                                            DEF_TRP, DEF_TRFC, DEF_BL);

endpackage

// File: rtl/timing_counter.sv
// Loadable down-counter that all timed bank states share. A load takes
// priority over counting. The counter decrements while enabled and stops
// at zero.
module timing_counter
  import ddr_fsm_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_count,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load on timed-state entry, otherwise count down to zero while enabled.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/bank_timing_fsm.sv
// DDR single-bank timing FSM. It accepts decoded command strobes, sequences
// the bank through activate/read/write/precharge/refresh with one shared
// down-counter, and flags rejected commands with a one-cycle illegal_cmd pulse.
// Optional feature: define BANK_TIMING_STATS_EN to enable the ACT/RD/WR
// statistics counters. Otherwise those ports are tied to zero.
module bank_timing_fsm
  import ddr_fsm_pkg::*;
#(
  parameter int unsigned tRCD = DEF_TRCD,
  parameter int unsigned tCL  = DEF_TCL,
  parameter int unsigned tCWL = DEF_TCWL,
  parameter int unsigned tRP  = DEF_TRP,
  parameter int unsigned tRFC = DEF_TRFC,
  parameter int unsigned BL   = DEF_BL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        ACT,
  input  logic        PR,
  input  logic        PRA,
  input  logic        RD,
  input  logic        RDA,
  input  logic        WR,
  input  logic        WRA,
  input  logic        REF,
  output logic [4:0]  state,
  output logic        busy,
  output logic        illegal_cmd,
  output logic [31:0] act_count,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  localparam int unsigned CW = cnt_width(tRCD, tCL, tCWL, tRP, tRFC, BL);

  // Values loaded into the counter on timed-state entry. A state loaded
  // with (N - 1) lasts exactly N cycles.
  localparam logic [CW-1:0] L_RCD = CW'(tRCD - 1);
  localparam logic [CW-1:0] L_CL  = CW'(tCL  - 1);
  localparam logic [CW-1:0] L_CWL = CW'(tCWL - 1);
  localparam logic [CW-1:0] L_RP  = CW'(tRP  - 1);
  localparam logic [CW-1:0] L_RFC = CW'(tRFC - 1);
  localparam logic [CW-1:0] L_BL  = CW'(BL   - 1);

  bank_state_e   r_state;
  bank_state_e   w_next_state;
  logic          r_flag;        // auto-precharge requested by RDA/WRA
  logic          w_flag_next;
  logic          r_illegal;
  logic          w_illegal;
  logic          w_load;
  logic [CW-1:0] w_load_val;
  logic [CW-1:0] w_count;
  logic          w_cnt_zero;
  logic [7:0]    w_cmd;
  logic          w_any;
  logic          w_multi;

  assign w_cmd   = {ACT, PR, PRA, RD, RDA, WR, WRA, REF};
  assign w_any   = |w_cmd;
  // Clearing the lowest set bit leaves a nonzero value only when two or
  // more strobes are asserted.
  assign w_multi = |(w_cmd & (w_cmd - 8'd1));

  // The counter freezes during halt. Loads come only from accepted transitions.
  timing_counter #(
    .W (CW)
  ) u_timing_counter (
    .clk        (clk),
    .rst        (rst),
    .i_en       (~halt),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_count    (w_count),
    .o_zero     (w_cnt_zero)
  );

  // Next-state, counter load, auto-precharge flag and illegal-command decode.
  // NOTE: every signal gets a default before any branch. A path that leaves
  // a combinational output unassigned infers a latch.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_load_val   = '0;
    w_illegal    = 1'b0;
    w_flag_next  = r_flag;
    if (!halt) begin
      case (r_state)
        S_IDLE: begin
          if (w_multi) begin
            w_illegal = 1'b1;
          end else if (ACT) begin
            w_next_state = S_ACTIVATING;
            w_load       = 1'b1;
            w_load_val   = L_RCD;
          end else if (REF) begin
            w_next_state = S_REFRESHING;
            w_load       = 1'b1;
            w_load_val   = L_RFC;
          end else if (RD | RDA | WR | WRA) begin
            w_illegal = 1'b1;
          end
          // A precharge command in IDLE is harmless and is dropped silently.
        end
        S_BANK_ACTIVE: begin
          if (w_multi) begin
            w_illegal = 1'b1;
          end else if (RD | RDA) begin
            w_next_state = S_READ_WAIT;
            w_load       = 1'b1;
            w_load_val   = L_CL;
            w_flag_next  = RDA;
          end else if (WR | WRA) begin
            w_next_state = S_WRITE_WAIT;
            w_load       = 1'b1;
            w_load_val   = L_CWL;
            w_flag_next  = WRA;
          end else if (PR | PRA) begin
            w_next_state = S_PRECHARGING;
            w_load       = 1'b1;
            w_load_val   = L_RP;
          end else if (ACT | REF) begin
            w_illegal = 1'b1;
          end
        end
        default: begin
          // Busy states reject every command and advance only on timeout.
          w_illegal = w_any;
          if (w_cnt_zero) begin
            case (r_state)
              S_ACTIVATING: w_next_state = S_BANK_ACTIVE;
              S_READ_WAIT: begin
                w_next_state = r_flag ? S_READING_AP : S_READING;
                w_load       = 1'b1;
                w_load_val   = L_BL;
              end
              S_WRITE_WAIT: begin
                w_next_state = r_flag ? S_WRITING_AP : S_WRITING;
                w_load       = 1'b1;
                w_load_val   = L_BL;
              end
              S_READING, S_WRITING: w_next_state = S_BANK_ACTIVE;
              S_READING_AP, S_WRITING_AP: begin
                w_next_state = S_PRECHARGING;
                w_load       = 1'b1;
                w_load_val   = L_RP;
              end
              S_PRECHARGING, S_REFRESHING: w_next_state = S_IDLE;
              default: w_next_state = S_IDLE;  // recover from undefined codes
            endcase
          end
        end
      endcase
    end
  end

  // State, flag and illegal-pulse registers. Halt already forces hold values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_flag    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_flag    <= w_flag_next;
      r_illegal <= w_illegal;
    end
  end

  assign state       = r_state;
  assign busy        = (r_state != S_IDLE) && (r_state != S_BANK_ACTIVE);
  assign illegal_cmd = r_illegal;

`ifdef BANK_TIMING_STATS_EN
  logic [31:0] r_act_count;
  logic [31:0] r_rd_count;
  logic [31:0] r_wr_count;
  logic        w_inc_act;
  logic        w_inc_rd;
  logic        w_inc_wr;

  // A command is accepted exactly when it moves the FSM out of its idle or
  // active resting state.
  assign w_inc_act = (r_state == S_IDLE)        && (w_next_state == S_ACTIVATING);
  assign w_inc_rd  = (r_state == S_BANK_ACTIVE) && (w_next_state == S_READ_WAIT);
  assign w_inc_wr  = (r_state == S_BANK_ACTIVE) && (w_next_state == S_WRITE_WAIT);

  // Statistics counters. They wrap naturally modulo 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_act_count <= '0;
      r_rd_count  <= '0;
      r_wr_count  <= '0;
    end else begin
      if (w_inc_act) r_act_count <= r_act_count + 32'd1;
      if (w_inc_rd)  r_rd_count  <= r_rd_count  + 32'd1;
      if (w_inc_wr)  r_wr_count  <= r_wr_count  + 32'd1;
    end
  end

  assign act_count = r_act_count;
  assign rd_count  = r_rd_count;
  assign wr_count  = r_wr_count;
`else
  assign act_count = '0;
  assign rd_count  = '0;
  assign wr_count  = '0;
`endif

endmodule
